// File: rtl/iter_divider_pkg.sv
// Shared divider definitions: default operand width and the 2-bit FSM
// state encodings used by iter_divider.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_CALC = 2'b01,
    DIV_DONE = 2'b10
  } div_state_t;

endpackage : iter_divider_pkg

// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider, one quotient bit per cycle.
// Signed/unsigned quotient and remainder, level-held request with abort,
// single-cycle completion pulse with registered results.
//
// Optional feature macro: DIV_SHORTCUT_EN
//   When defined, an accepted request with |y| != 0 and |x| < |y| skips the
//   iteration and completes in the cycle after acceptance (s=0, r=x).
//   When undefined, every operation runs the full WIDTH iterations.
//   Results are identical in both builds; only latency differs.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// DIV_IDLE | waiting for div; div=1 at an edge accepts the operands
// DIV_CALC | one shift/subtract step per cycle, cnt counts 0..WIDTH-1
// DIV_DONE | complete=1 for this single cycle, s/r freshly registered
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             complete,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  div_state_t       state;
  logic [CW-1:0]    cnt;
  logic             sign_q;
  logic             sign_r;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dsr;

  logic [WIDTH-1:0] x_abs;
  logic [WIDTH-1:0] y_abs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] dvd_next;

  // Operand magnitudes; negation only applies to negative signed operands.
  always_comb begin
    x_abs = (div_signed && x[WIDTH-1]) ? -x : x;
    y_abs = (div_signed && y[WIDTH-1]) ? -y : y;
  end

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor. The extra top bit of the
  // subtractor is the borrow, so a shifted remainder above 2^WIDTH-1
  // still compares correctly.
  always_comb begin
    rem_sh   = {rem, dvd[WIDTH-1]};
    diff     = rem_sh - {1'b0, dsr};
    q_bit    = ~diff[WIDTH];
    rem_next = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    dvd_next = {dvd[WIDTH-2:0], q_bit};
  end

`ifdef DIV_SHORTCUT_EN
  logic short_hit;

  // Quotient is zero whenever the dividend magnitude is below a non-zero
  // divisor magnitude, so the remainder is simply the original dividend.
  always_comb begin
    short_hit = (y_abs != '0) && (x_abs < y_abs);
  end
`endif

  // Sequencing FSM with registered results, completion pulse and busy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= DIV_IDLE;
      cnt      <= '0;
      sign_q   <= 1'b0;
      sign_r   <= 1'b0;
      rem      <= '0;
      dvd      <= '0;
      dsr      <= '0;
      s        <= '0;
      r        <= '0;
      complete <= 1'b0;
      busy     <= 1'b0;
    end else begin
      complete <= 1'b0;
      case (state)
        DIV_IDLE: begin
          if (div) begin
            sign_q <= (x[WIDTH-1] ^ y[WIDTH-1]) & div_signed;
            sign_r <= x[WIDTH-1] & div_signed;
            dvd    <= x_abs;
            dsr    <= y_abs;
            rem    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
`ifdef DIV_SHORTCUT_EN
            if (short_hit) begin
              state    <= DIV_DONE;
              s        <= '0;
              r        <= x;
              complete <= 1'b1;
            end else begin
              state <= DIV_CALC;
            end
`else
            state <= DIV_CALC;
`endif
          end
        end

        DIV_CALC: begin
          // Dropping the request abandons the operation; results untouched.
          if (!div) begin
            state <= DIV_IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= rem_next;
            dvd <= dvd_next;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              state    <= DIV_DONE;
              s        <= sign_q ? -dvd_next : dvd_next;
              r        <= sign_r ? -rem_next : rem_next;
              complete <= 1'b1;
            end
          end
        end

        DIV_DONE: begin
          // A request still held here belongs to the finished operation.
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state <= DIV_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule : iter_divider
